// File: rtl/dac_multich_controller.sv
// dac_multich_controller
//   Multi-channel DAC command sequencer. After reset it sends the
//   internal-reference setup word (28'h8000001). It then waits in IDLE for a
//   frame trigger and writes every enabled channel's sample, in ascending
//   channel order, to the downstream SPI serializer via the go_DAC/trans
//   handshake. A start-timeout flags a serializer that never goes busy.
//
//   Build option: define DAC_CTRL_SYNC_UPDATE_EN for simultaneous update
//   (non-final words cmd 0, final word cmd 2). Undefined: every channel word
//   uses cmd 3 (write and update n).
//
// Ports
//   clk            rising-edge clock
//   reset_Async_n  asynchronous active-low reset
//   DAC_D          channel samples, channel k at [k*DW +: DW]
//   ch_en          channel enable mask, sampled at frame start
//   frame_go       frame trigger, level-sampled in IDLE
//   reinit         re-send setup word, sampled in IDLE (wins over frame_go)
//   trans          serializer busy
//   DAC_in         registered command word {cmd[3:0], addr[3:0], data[19:0]}
//   go_DAC         registered one-cycle transfer start pulse
//   busy           high whenever the sequencer is not idle
//   init_done      setup word completed at least once since reset
//   frame_done     one-cycle pulse at end of a frame
//   err            sticky start-timeout flag, cleared by reinit
module dac_multich_controller #(
  parameter int N_CH     = 4,
  parameter int DW       = 12,
  parameter int START_TO = 16
) (
  input  logic                 clk,
  input  logic                 reset_Async_n,
  input  logic [N_CH*DW-1:0]   DAC_D,
  input  logic [N_CH-1:0]      ch_en,
  input  logic                 frame_go,
  input  logic                 reinit,
  input  logic                 trans,
  output logic [27:0]          DAC_in,
  output logic                 go_DAC,
  output logic                 busy,
  output logic                 init_done,
  output logic                 frame_done,
  output logic                 err
);

  localparam logic [2:0] S_INIT_LD = 3'd0;
  localparam logic [2:0] S_IDLE    = 3'd1;
  localparam logic [2:0] S_GO      = 3'd2;
  localparam logic [2:0] S_WS      = 3'd3;
  localparam logic [2:0] S_WD      = 3'd4;
  localparam logic [2:0] S_NEXT    = 3'd5;

  localparam logic [27:0] SETUP_WORD = 28'h8000001;
  localparam logic [7:0]  TO_LAST    = 8'(START_TO - 1);

  logic [2:0]          state;
  logic                boot_pend;   // forces one setup pass out of reset
  logic                init_flag;   // current word is the setup word
  logic [7:0]          to_cnt;
  logic [3:0]          cur;
  logic [N_CH-1:0]     sh_en;
  logic [N_CH*DW-1:0]  sh_d;

  // Channel selection: in IDLE search the live inputs (captured on the same
  // edge), otherwise search the shadow mask above the current channel.
  logic [N_CH-1:0]     src_en;
  logic [N_CH*DW-1:0]  src_d;
  logic                sel_found;
  logic [3:0]          sel_ch;
  logic [DW-1:0]       sel_data;
  logic [19:0]         sel_d20;
  logic [3:0]          sel_cmd;
  logic [27:0]         sel_word;
`ifdef DAC_CTRL_SYNC_UPDATE_EN
  logic                sel_last;
`endif

  always_comb begin
    src_en    = (state == S_IDLE) ? ch_en : sh_en;
    src_d     = (state == S_IDLE) ? DAC_D : sh_d;
    sel_found = 1'b0;
    sel_ch    = '0;
    sel_data  = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (!sel_found && src_en[k] && ((state == S_IDLE) || (4'(k) > cur))) begin
        sel_found = 1'b1;
        sel_ch    = 4'(k);
        sel_data  = src_d[k*DW +: DW];
      end
    end
    sel_d20 = 20'(sel_data) << (20 - DW);
`ifdef DAC_CTRL_SYNC_UPDATE_EN
    sel_last = 1'b1;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (src_en[k] && (4'(k) > sel_ch))
        sel_last = 1'b0;
    end
    sel_cmd = sel_last ? 4'd2 : 4'd0;
`else
    sel_cmd = 4'd3;
`endif
    sel_word = {sel_cmd, sel_ch, sel_d20};
  end

  // busy is registered alongside the state so it reads 0 during reset and
  // goes high on the first edge after release (state leaves IDLE for INIT_LD).
  always_ff @(posedge clk or negedge reset_Async_n) begin
    if (!reset_Async_n) begin
      state      <= S_IDLE;
      boot_pend  <= 1'b1;
      init_flag  <= 1'b0;
      to_cnt     <= '0;
      cur        <= '0;
      sh_en      <= '0;
      sh_d       <= '0;
      DAC_in     <= '0;
      go_DAC     <= 1'b0;
      busy       <= 1'b0;
      init_done  <= 1'b0;
      frame_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      go_DAC     <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (boot_pend || reinit) begin
            boot_pend <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b1;
            state     <= S_INIT_LD;
          end else if (frame_go) begin
            sh_en <= ch_en;
            sh_d  <= DAC_D;
            if (sel_found) begin
              DAC_in <= sel_word;
              cur    <= sel_ch;
              busy   <= 1'b1;
              state  <= S_GO;
            end else begin
              frame_done <= 1'b1;
            end
          end
        end
        S_INIT_LD: begin
          DAC_in    <= SETUP_WORD;
          init_flag <= 1'b1;
          state     <= S_GO;
        end
        S_GO: begin
          go_DAC <= 1'b1;
          to_cnt <= '0;
          state  <= S_WS;
        end
        S_WS: begin
          // First WS edge coincides with the go_DAC cycle; trans is ignored there.
          if ((to_cnt != '0) && trans) begin
            state <= S_WD;
          end else if (to_cnt == TO_LAST) begin
            err   <= 1'b1;
            state <= S_NEXT;
          end else begin
            to_cnt <= to_cnt + 8'd1;
          end
        end
        S_WD: begin
          if (!trans)
            state <= S_NEXT;
        end
        S_NEXT: begin
          if (init_flag) begin
            init_flag <= 1'b0;
            init_done <= 1'b1;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end else if (sel_found) begin
            DAC_in <= sel_word;
            cur    <= sel_ch;
            state  <= S_GO;
          end else begin
            frame_done <= 1'b1;
            busy       <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dac_multich_controller.sv
module tb_dac_multich_controller;

  localparam int N_CH = 4;
  localparam int DW   = 12;
  localparam int TO   = 16;

  logic                clk = 1'b0;
  logic                reset_Async_n = 1'b0;
  logic [N_CH*DW-1:0]  DAC_D = '0;
  logic [N_CH-1:0]     ch_en = '0;
  logic                frame_go = 1'b0;
  logic                reinit = 1'b0;
  logic                trans = 1'b0;
  logic [27:0]         DAC_in;
  logic                go_DAC;
  logic                busy;
  logic                init_done;
  logic                frame_done;
  logic                err;

  int n_tests = 0;
  int n_fail  = 0;
  int n_go    = 0;
  int n_fd    = 0;
  bit ser_en  = 1'b1;

  logic [27:0] exp_q[$];

`ifdef DAC_CTRL_SYNC_UPDATE_EN
  localparam logic [27:0] W_CH1 = 28'h01ABC00;
  localparam logic [27:0] W_CH3 = 28'h2312300;
  localparam logic [27:0] W_CH0 = 28'h205A500;
`else
  localparam logic [27:0] W_CH1 = 28'h31ABC00;
  localparam logic [27:0] W_CH3 = 28'h3312300;
  localparam logic [27:0] W_CH0 = 28'h305A500;
`endif
  localparam logic [27:0] W_SETUP = 28'h8000001;

  dac_multich_controller #(.N_CH(N_CH), .DW(DW), .START_TO(TO)) dut (
    .clk           (clk),
    .reset_Async_n (reset_Async_n),
    .DAC_D         (DAC_D),
    .ch_en         (ch_en),
    .frame_go      (frame_go),
    .reinit        (reinit),
    .trans         (trans),
    .DAC_in        (DAC_in),
    .go_DAC        (go_DAC),
    .busy          (busy),
    .init_done     (init_done),
    .frame_done    (frame_done),
    .err           (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Serializer model: goes busy in the go_DAC cycle and stays busy 5 cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (go_DAC && ser_en) begin
        trans = 1'b1;
        repeat (5) @(negedge clk);
        trans = 1'b0;
      end
    end
  end

  // Scoreboard: each go_DAC pops the next expected word.
  always @(negedge clk) begin
    if (go_DAC) begin
      n_go++;
      if (exp_q.size() == 0) begin
        chk("unexpected_go", {4'h0, DAC_in}, 32'hFFFFFFFF);
      end else begin
        chk("word", {4'h0, DAC_in}, {4'h0, exp_q.pop_front()});
      end
    end
    if (frame_done) n_fd++;
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_DAC_in", {4'h0, DAC_in}, 32'h0);
    chk("rst_go", {31'h0, go_DAC}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_init_done", {31'h0, init_done}, 32'h0);
    chk("rst_frame_done", {31'h0, frame_done}, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);

    // Setup sequence after release
    exp_q.push_back(W_SETUP);
    @(negedge clk) reset_Async_n = 1'b1;
    @(posedge clk); #1;
    chk("edge1_busy", {31'h0, busy}, 32'h1);
    @(posedge clk); #1;
    chk("edge2_DAC_in", {4'h0, DAC_in}, {4'h0, W_SETUP});
    chk("edge2_go", {31'h0, go_DAC}, 32'h0);
    @(posedge clk); #1;
    chk("edge3_go", {31'h0, go_DAC}, 32'h1);
    for (int i = 0; i < 100 && !init_done; i++) begin @(posedge clk); #1; end
    chk("init_done", {31'h0, init_done}, 32'h1);
    chk("init_busy", {31'h0, busy}, 32'h0);
    chk("init_go_count", n_go, 1);

    // Frame ch1/ch3, with a change of samples and a re-pulsed frame_go mid-frame
    ch_en = 4'b1010;
    DAC_D = '0;
    DAC_D[1*DW +: DW] = 12'hABC;
    DAC_D[3*DW +: DW] = 12'h123;
    exp_q.push_back(W_CH1);
    exp_q.push_back(W_CH3);
    @(negedge clk) frame_go = 1'b1;
    @(posedge clk); #1;
    frame_go = 1'b0;
    chk("frame_DAC_in", {4'h0, DAC_in}, {4'h0, W_CH1});
    chk("frame_busy", {31'h0, busy}, 32'h1);
    chk("frame_go_early", {31'h0, go_DAC}, 32'h0);
    DAC_D = '1;
    frame_go = 1'b1;
    @(posedge clk); #1;
    chk("frame_go_E1", {31'h0, go_DAC}, 32'h1);
    repeat (2) @(posedge clk);
    #1 frame_go = 1'b0;
    for (int i = 0; i < 200 && !frame_done; i++) begin @(posedge clk); #1; end
    chk("frame_done", {31'h0, frame_done}, 32'h1);
    repeat (5) @(posedge clk);
    #1;
    chk("frame_go_count", n_go, 3);
    chk("frame_fd_count", n_fd, 1);
    chk("frame_idle", {31'h0, busy}, 32'h0);

    // Empty-mask frame
    ch_en = 4'b0000;
    @(negedge clk) frame_go = 1'b1;
    @(posedge clk); #1;
    frame_go = 1'b0;
    chk("empty_fd", {31'h0, frame_done}, 32'h1);
    chk("empty_busy", {31'h0, busy}, 32'h0);
    @(posedge clk); #1;
    chk("empty_fd_clear", {31'h0, frame_done}, 32'h0);
    repeat (4) @(posedge clk);
    #1;
    chk("empty_go_count", n_go, 3);

    // Dead serializer: timeout
    ser_en = 1'b0;
    exp_q.push_back(W_SETUP);
    @(negedge clk) reinit = 1'b1;
    @(posedge clk); #1;
    reinit = 1'b0;
    for (int i = 0; i < 20 && !go_DAC; i++) begin @(posedge clk); #1; end
    chk("to_go", {31'h0, go_DAC}, 32'h1);
    repeat (15) @(posedge clk);
    #1;
    chk("to_err_early", {31'h0, err}, 32'h0);
    @(posedge clk); #1;
    chk("to_err", {31'h0, err}, 32'h1);
    for (int i = 0; i < 20 && busy; i++) begin @(posedge clk); #1; end
    chk("to_idle", {31'h0, busy}, 32'h0);

    // reinit clears err and resends setup
    ser_en = 1'b1;
    exp_q.push_back(W_SETUP);
    @(negedge clk) reinit = 1'b1;
    @(posedge clk); #1;
    reinit = 1'b0;
    chk("reinit_err_clr", {31'h0, err}, 32'h0);
    for (int i = 0; i < 100 && busy; i++) begin @(posedge clk); #1; end
    chk("reinit_idle", {31'h0, busy}, 32'h0);
    chk("reinit_go_count", n_go, 5);
    chk("reinit_err_stays", {31'h0, err}, 32'h0);

    // Reset during WD of a channel word
    ch_en = 4'b0001;
    DAC_D = '0;
    DAC_D[0 +: DW] = 12'h5A5;
    exp_q.push_back(W_CH0);
    @(negedge clk) frame_go = 1'b1;
    @(posedge clk); #1;
    frame_go = 1'b0;
    for (int i = 0; i < 20 && !trans; i++) @(negedge clk);
    chk("mid_trans", {31'h0, trans}, 32'h1);
    repeat (3) @(posedge clk);
    #2 reset_Async_n = 1'b0;
    #1;
    chk("mid_rst_go", {31'h0, go_DAC}, 32'h0);
    chk("mid_rst_busy", {31'h0, busy}, 32'h0);
    chk("mid_rst_DAC_in", {4'h0, DAC_in}, 32'h0);
    chk("mid_rst_init_done", {31'h0, init_done}, 32'h0);
    repeat (8) @(posedge clk);
    exp_q.push_back(W_SETUP);
    @(negedge clk) reset_Async_n = 1'b1;
    for (int i = 0; i < 100 && !init_done; i++) begin @(posedge clk); #1; end
    chk("rerun_init_done", {31'h0, init_done}, 32'h1);
    chk("rerun_go_count", n_go, 7);
    chk("queue_empty", exp_q.size(), 0);
    chk("fd_total", n_fd, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dac_multich_controller.md
# dac_multich_controller

Parametrised multi-channel successor to the single-channel DAC command sequencer. After reset it sends one internal-reference setup word to the DAC. It then waits for a frame trigger and writes every enabled channel's sample in ascending channel order. Each command word goes to the downstream SPI serializer over the existing `go_DAC`/`trans` handshake. A start-timeout detects a dead serializer.

## Interface
Parameters:
- `N_CH`, 4: channel count, 1..8; the channel index is the DAC address.
- `DW`, 12: sample width, 8..20.
- `START_TO`, 16: cycles allowed after `go_DAC` for `trans` to rise, 2..255.

Ports:
- `clk` in 1: single clock; everything is rising-edge.
- `reset_Async_n` in 1: asynchronous, active-low reset.
- `DAC_D` in N_CH*DW: channel samples; channel k is at [k*DW +: DW].
- `ch_en` in N_CH: channel enable mask, sampled at frame start.
- `frame_go` in 1: frame trigger, level-sampled in IDLE.
- `reinit` in 1: re-send the setup word, sampled in IDLE.
- `trans` in 1: serializer busy.
- `DAC_in` out 28: command word to the serializer (registered).
- `go_DAC` out 1: one-cycle transfer start pulse (registered).
- `busy` out 1: high in any state other than IDLE.
- `init_done` out 1: setup word has completed at least once since reset.
- `frame_done` out 1: one-cycle pulse at the end of a frame.
- `err` out 1: sticky start-timeout flag.

## Operation
- Word format: {cmd[3:0], addr[3:0], data[19:0]}.
  - Sample occupies data[19:20-DW]; the remaining low bits are 0.
  - Setup word = {4'd8, 4'd0, 20'd1} = 28'h8000001.
- States: INIT_LD, IDLE, GO, WS, WD, NEXT.
- INIT_LD: load the setup word into `DAC_in`, then go to GO with the init flag set.
- GO: `go_DAC`=1 for exactly this cycle, clear the timeout counter, then go to WS.
- WS: wait for `trans`=1, then go to WD.
  - If the counter reaches START_TO first: set `err` and treat the word as done (go to NEXT).
- WD: wait for `trans`=0, then go to NEXT.
- NEXT:
  - If the init flag is set: set `init_done`, clear the flag, go to IDLE.
  - Otherwise: select the next higher enabled channel, load its word, go to GO.
  - If no enabled channel remains: pulse `frame_done` and go to IDLE.
- IDLE, in priority order:
  - `reinit`=1: clear `err` and go to INIT_LD.
  - `frame_go`=1: capture all of `DAC_D` and `ch_en` into shadow registers, load the lowest enabled channel's word, go to GO.
  - Both asserted in the same cycle: `reinit` wins and `frame_go` is dropped.
- `frame_go` with `ch_en`=0: no transfer; `frame_done` pulses on the next cycle.
- `frame_go` and `reinit` while `busy`: ignored, not queued.
- Shadow registers hold the samples for the whole frame; `DAC_D` may change freely after capture.
- `DAC_in` is stable from the cycle before `go_DAC` until the word is done.

## Timing
- While reset is asserted, all outputs are 0: `DAC_in`=0, `go_DAC`=0, `busy`=0, `init_done`=0, `frame_done`=0, `err`=0.
- First edge after reset release: state is INIT_LD and `busy`=1.
  - `DAC_in`=28'h8000001 after the 2nd edge.
  - `go_DAC` is high after the 3rd edge.
- Frame start: `frame_go` is sampled at edge E.
  - `DAC_in` is valid after E.
  - `go_DAC` is high for the cycle after E+1.
- Per-word overhead outside the serializer's busy time is 3 cycles: GO, plus the edge that samples `trans`=0, plus NEXT.
- `trans` rising in the same cycle as `go_DAC` is not seen; WS starts checking on the following edge.
- Reset asserted mid-transfer: outputs clear immediately and the full setup sequence reruns after release.

## Configuration
- `DAC_CTRL_SYNC_UPDATE_EN` defined (simultaneous update):
  - Each non-final channel word uses cmd 4'd0 (write input register).
  - The last enabled channel's word uses cmd 4'd2 (write n, update all).
  - With one channel enabled, that single word uses cmd 4'd2.
- Not defined (per-channel update): every channel word uses cmd 4'd3 (write and update n).

## Test plan
- Reset release, serializer model holds `trans` high for 5 cycles after each `go_DAC` -> one `go_DAC` with `DAC_in`=28'h8000001, then `init_done`=1, `busy`=0.
- N_CH=4, DW=12, `ch_en`=4'b1010, samples ch1=12'hABC and ch3=12'h123, macro undefined -> words 28'h31ABC00 then 28'h3312300, followed by a single `frame_done` pulse.
- Same stimulus with `DAC_CTRL_SYNC_UPDATE_EN` defined -> words 28'h01ABC00 then 28'h2312300.
- `trans` tied 0, START_TO=16 -> `err`=1 exactly 16 cycles after the setup word's `go_DAC`. A later `reinit` clears `err` and resends 28'h8000001.
- Frame under way: `DAC_D` changed and `frame_go` re-pulsed -> second `frame_go` is ignored and the words carry the captured samples. A later `frame_go` with `ch_en`=0 produces `frame_done` one cycle later and no `go_DAC`.
- `reset_Async_n` low during WD of a channel word -> `go_DAC`/`busy`/`DAC_in` are 0 immediately, and the setup word is reissued after release.
